// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port instruction/data bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_BUSY  = 3'd1,
        ST_MEM_BUSY = 3'd2,
        ST_IF_DROP  = 3'd3,
        ST_RESP     = 3'd4
    } arb_state_t;

    localparam logic        SRC_IF     = 1'b0;
    localparam logic        SRC_MEM    = 1'b1;
    localparam logic        PRIO_RR    = 1'b0;
    localparam logic        PRIO_MEM   = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [3:0]  SEL_WORD   = 4'b1111;
    localparam logic [3:0]  SEL_NONE   = 4'b0000;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational grant decision between fetch and data requesters.
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter logic MEM_PRIO = PRIO_MEM
) (
    input  logic if_ce,
    input  logic mem_req,
    input  logic last,
    output logic grant_valid,
    output logic grant_mem
);

    // On a tie, fixed priority favours data; round-robin favours the side not served last.
    always_comb begin
        grant_valid = if_ce | mem_req;
        grant_mem   = 1'b0;
        if (if_ce && mem_req) begin
            if (MEM_PRIO == PRIO_MEM) begin
                grant_mem = 1'b1;
            end else begin
                grant_mem = (last == SRC_IF);
            end
        end else begin
            grant_mem = mem_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter owning the one external memory bus, shared by instruction fetch and the MEM stage.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic MEM_PRIO = PRIO_MEM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        stallreq,
    output logic        bus_cyc,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    arb_state_t state_r;
    logic       last_r;
    logic       mem_drop_r;
    logic       grant_valid_s;
    logic       grant_mem_s;

    arb_pick #(
        .MEM_PRIO (MEM_PRIO)
    ) u_pick (
        .if_ce       (if_ce),
        .mem_req     (mem_req),
        .last        (last_r),
        .grant_valid (grant_valid_s),
        .grant_mem   (grant_mem_s)
    );

    // Stall lifts only in the cycle the data response is actually delivered.
    always_comb begin
        stallreq = mem_req & ~((state_r == ST_RESP) & mem_ready);
    end

    // Arbitration FSM with registered bus request and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            last_r     <= SRC_IF;
            mem_drop_r <= 1'b0;
            bus_cyc    <= 1'b0;
            bus_we     <= 1'b0;
            bus_sel    <= SEL_NONE;
            bus_addr   <= ZERO_WORD;
            bus_wdata  <= ZERO_WORD;
            if_inst    <= ZERO_WORD;
            mem_rdata  <= ZERO_WORD;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    if (!flush && grant_valid_s) begin
                        bus_cyc <= 1'b1;
                        if (grant_mem_s) begin
                            state_r    <= ST_MEM_BUSY;
                            last_r     <= SRC_MEM;
                            mem_drop_r <= 1'b0;
                            bus_we     <= mem_we;
                            bus_sel    <= mem_sel;
                            bus_addr   <= mem_addr;
                            bus_wdata  <= mem_wdata;
                        end else begin
                            state_r   <= ST_IF_BUSY;
                            last_r    <= SRC_IF;
                            bus_we    <= 1'b0;
                            bus_sel   <= SEL_WORD;
                            bus_addr  <= if_addr;
                            bus_wdata <= ZERO_WORD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IF_BUSY: begin
                    if (bus_ack) begin
                        bus_cyc <= 1'b0;
                        state_r <= ST_RESP;
                        if (!flush) begin
                            if_inst  <= bus_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            if_ready <= 1'b0;
                        end
                    end else if (flush) begin
                        state_r <= ST_IF_DROP;
                    end else begin
                        state_r <= ST_IF_BUSY;
                    end
                end
                ST_IF_DROP: begin
                    // The bus cannot abort, so the stale fetch is allowed to finish silently.
                    if (bus_ack) begin
                        bus_cyc <= 1'b0;
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_IF_DROP;
                    end
                end
                ST_MEM_BUSY: begin
                    if (bus_ack) begin
                        bus_cyc   <= 1'b0;
                        state_r   <= ST_RESP;
                        mem_ready <= ~(flush | mem_drop_r);
                        if (!bus_we) begin
                            mem_rdata <= bus_rdata;
                        end else begin
                            mem_rdata <= mem_rdata;
                        end
                    end else if (flush) begin
                        mem_drop_r <= 1'b1;
                    end else begin
                        state_r <= ST_MEM_BUSY;
                    end
                end
                ST_RESP: begin
                    // Dead cycle: requesters see the pulse before they can be granted again.
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_cyc   <= 1'b0;
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (fixed-priority and round-robin instances).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        if_ce = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;

    logic [31:0] if_inst, mem_rdata, bus_addr, bus_wdata;
    logic        if_ready, mem_ready, stallreq, bus_cyc, bus_we;
    logic [3:0]  bus_sel;

    logic [31:0] rr_if_inst, rr_mem_rdata, rr_bus_addr, rr_bus_wdata;
    logic        rr_if_ready, rr_mem_ready, rr_stallreq, rr_bus_cyc, rr_bus_we;
    logic [3:0]  rr_bus_sel;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_PRIO(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .if_ce(if_ce), .if_addr(if_addr),
        .if_inst(if_inst), .if_ready(if_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stallreq(stallreq),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    mem_arbiter #(.MEM_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .flush(flush), .if_ce(if_ce), .if_addr(if_addr),
        .if_inst(rr_if_inst), .if_ready(rr_if_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(rr_mem_rdata), .mem_ready(rr_mem_ready), .stallreq(rr_stallreq),
        .bus_cyc(rr_bus_cyc), .bus_we(rr_bus_we), .bus_sel(rr_bus_sel), .bus_addr(rr_bus_addr),
        .bus_wdata(rr_bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total++; if (bus_cyc !== 1'b0) begin bad++; $display("FAIL reset_bus_cyc got=%b exp=0", bus_cyc); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); end
        total++; if (bus_sel !== 4'h0 || bus_we !== 1'b0 || bus_wdata !== 32'h0) begin bad++; $display("FAIL reset_bus_fields sel=%h we=%b wdata=%h exp=0", bus_sel, bus_we, bus_wdata); end
        total++; if (if_inst !== 32'h0 || mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_data inst=%h rdata=%h exp=0", if_inst, mem_rdata); end
        total++; if (if_ready !== 1'b0 || mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready if=%b mem=%b exp=0", if_ready, mem_ready); end
        total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stallreq); end
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        if_ce = 1'b1;
        if_addr = 32'hbfc0_0000;
        tick();
        total++; if (bus_cyc !== 1'b1 || bus_addr !== 32'hbfc0_0000) begin bad++; $display("FAIL fetch_grant cyc=%b addr=%h exp=1 bfc00000", bus_cyc, bus_addr); end
        total++; if (bus_we !== 1'b0 || bus_sel !== 4'hf) begin bad++; $display("FAIL fetch_fields we=%b sel=%h exp=0 f", bus_we, bus_sel); end
        tick();
        tick();
        total++; if (if_ready !== 1'b0 || bus_cyc !== 1'b1) begin bad++; $display("FAIL fetch_wait ready=%b cyc=%b exp=0 1", if_ready, bus_cyc); end
        bus_ack = 1'b1;
        bus_rdata = 32'h3c01_1234;
        tick();
        total++; if (if_ready !== 1'b1 || if_inst !== 32'h3c01_1234) begin bad++; $display("FAIL fetch_resp ready=%b inst=%h exp=1 3c011234", if_ready, if_inst); end
        total++; if (bus_cyc !== 1'b0) begin bad++; $display("FAIL fetch_cyc_drop got=%b exp=0", bus_cyc); end
        bus_ack = 1'b0;
        if_ce = 1'b0;
        tick();
        total++; if (if_ready !== 1'b0 || if_inst !== 32'h3c01_1234) begin bad++; $display("FAIL fetch_pulse_end ready=%b inst=%h exp=0 3c011234", if_ready, if_inst); end
        tick();
        total++; if (bus_cyc !== 1'b0) begin bad++; $display("FAIL fetch_idle cyc=%b exp=0", bus_cyc); end
    endtask

    task automatic test_priority();
        if_ce = 1'b1;
        if_addr = 32'h0000_0100;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_sel = 4'hf;
        mem_addr = 32'h8000_0010;
        #1;
        total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL prio_stall_req got=%b exp=1", stallreq); end
        tick();
        total++; if (bus_addr !== 32'h8000_0010 || bus_cyc !== 1'b1) begin bad++; $display("FAIL prio_mem_first addr=%h cyc=%b exp=80000010 1", bus_addr, bus_cyc); end
        total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL prio_stall_busy got=%b exp=1", stallreq); end
        bus_ack = 1'b1;
        bus_rdata = 32'h1111_2222;
        tick();
        total++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h1111_2222) begin bad++; $display("FAIL prio_mem_resp ready=%b rdata=%h exp=1 11112222", mem_ready, mem_rdata); end
        total++; if (stallreq !== 1'b0 || if_ready !== 1'b0) begin bad++; $display("FAIL prio_resp_flags stall=%b if_ready=%b exp=0 0", stallreq, if_ready); end
        mem_req = 1'b0;
        bus_ack = 1'b0;
        tick();
        total++; if (bus_cyc !== 1'b0 || mem_ready !== 1'b0) begin bad++; $display("FAIL prio_dead_cycle cyc=%b ready=%b exp=0 0", bus_cyc, mem_ready); end
        tick();
        total++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h0000_0100) begin bad++; $display("FAIL prio_if_second cyc=%b addr=%h exp=1 00000100", bus_cyc, bus_addr); end
        bus_ack = 1'b1;
        bus_rdata = 32'h2402_0001;
        tick();
        total++; if (if_ready !== 1'b1 || if_inst !== 32'h2402_0001) begin bad++; $display("FAIL prio_if_resp ready=%b inst=%h exp=1 24020001", if_ready, if_inst); end
        bus_ack = 1'b0;
        if_ce = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_flush_fetch();
        if_ce = 1'b1;
        if_addr = 32'h0000_0200;
        tick();
        total++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h0000_0200) begin bad++; $display("FAIL flush_grant cyc=%b addr=%h exp=1 00000200", bus_cyc, bus_addr); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if_addr = 32'h0000_0300;
        tick();
        tick();
        total++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h0000_0200) begin bad++; $display("FAIL flush_hold cyc=%b addr=%h exp=1 00000200", bus_cyc, bus_addr); end
        bus_ack = 1'b1;
        bus_rdata = 32'hdead_beef;
        tick();
        total++; if (if_ready !== 1'b0 || if_inst !== 32'h2402_0001) begin bad++; $display("FAIL flush_drop ready=%b inst=%h exp=0 24020001", if_ready, if_inst); end
        total++; if (bus_cyc !== 1'b0) begin bad++; $display("FAIL flush_cyc_drop got=%b exp=0", bus_cyc); end
        bus_ack = 1'b0;
        tick();
        tick();
        total++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h0000_0300) begin bad++; $display("FAIL flush_regrant cyc=%b addr=%h exp=1 00000300", bus_cyc, bus_addr); end
        bus_ack = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        total++; if (if_ready !== 1'b1 || if_inst !== 32'h1234_5678) begin bad++; $display("FAIL flush_next_resp ready=%b inst=%h exp=1 12345678", if_ready, if_inst); end
        bus_ack = 1'b0;
        if_ce = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_store();
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_sel = 4'b0011;
        mem_addr = 32'h8000_0020;
        mem_wdata = 32'h0000_abcd;
        tick();
        mem_wdata = 32'h5555_5555;
        mem_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus_cyc !== 1'b1 || bus_we !== 1'b1 || bus_sel !== 4'b0011 ||
                bus_addr !== 32'h8000_0020 || bus_wdata !== 32'h0000_abcd) begin
                bad++;
                $display("FAIL store_hold%0d cyc=%b we=%b sel=%h addr=%h wdata=%h exp=1 1 3 80000020 0000abcd",
                         i, bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata);
            end
            tick();
        end
        bus_ack = 1'b1;
        bus_rdata = 32'hffff_ffff;
        tick();
        total++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h1111_2222) begin bad++; $display("FAIL store_resp ready=%b rdata=%h exp=1 11112222", mem_ready, mem_rdata); end
        bus_ack = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        if_ce = 1'b1;
        if_addr = 32'h0000_0400;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_sel = 4'hf;
        mem_addr = 32'h0000_0500;
        bus_ack = 1'b1;
        bus_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 32'h0000_0500 : 32'h0000_0400;
            tick();
            total++; if (rr_bus_cyc !== 1'b1 || rr_bus_addr !== exp_addr) begin bad++; $display("FAIL rr_grant%0d cyc=%b addr=%h exp=1 %h", i, rr_bus_cyc, rr_bus_addr, exp_addr); end
            tick();
            tick();
        end
        if_ce = 1'b0;
        mem_req = 1'b0;
        bus_ack = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 32'h0000_0600;
        tick();
        total++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h0000_0600) begin bad++; $display("FAIL rstmid_grant cyc=%b addr=%h exp=1 00000600", bus_cyc, bus_addr); end
        mem_req = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        total++; if (bus_cyc !== 1'b0) begin bad++; $display("FAIL rstmid_async cyc=%b exp=0", bus_cyc); end
        tick();
        rst = 1'b1;
        bus_ack = 1'b1;
        bus_rdata = 32'haaaa_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (mem_ready !== 1'b0 || if_ready !== 1'b0 || bus_cyc !== 1'b0) begin bad++; $display("FAIL rstmid_quiet%0d mem=%b if=%b cyc=%b exp=0 0 0", i, mem_ready, if_ready, bus_cyc); end
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_flush_fetch();
        test_store();
        test_round_robin();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
